taus88_req_arbiter: RTL and testbench

Round-robin scheduler that shares one Taus88 RNG core among `NUM_REQ` requesters. It sequences the core through post-reset and post-reseed warm-up, and advances the core only when a word is consumed, so no word is ever delivered twice. It also serialises seed loads against consumption. It sits between the `taus88_core` instance and the consumer blocks.

---
 rtl/taus88_arb_pkg.sv | 16 +
 rtl/taus88_req_arbiter_rr_pick.sv | 40 ++++
 rtl/taus88_req_arbiter.sv | 122 ++++++++++++
 tb/tb_taus88_req_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taus88_arb_pkg.sv
// Shared types and constants for the Taus88 request arbiter: scheduler states,
// statistics counter width and parameter defaults/limits.
package taus88_arb_pkg;

   typedef enum logic [1:0] {
      RESET_WAIT,
      WARMUP,
      SERVE,
      RESEED
   } arb_state_t;

   localparam int STAT_W           = 16;
   localparam int DEFAULT_WARMUP_N = 8;
   localparam int MAX_NUM_REQ      = 16;

endpackage

// File: rtl/taus88_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping to the lowest index when nothing at or above the pointer is set.
module rr_pick
   import taus88_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] pick_oh,
   output logic [PTR_W-1:0]   pick_idx,
   output logic               any_req
);

   // Upper pass honours the pointer; lower pass only fires when the upper one found nothing.
   always_comb begin
      logic found;
      found    = 1'b0;
      pick_oh  = '0;
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i >= int'(rr_ptr))) begin
            found       = 1'b1;
            pick_oh[i]  = 1'b1;
            pick_idx    = PTR_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found       = 1'b1;
            pick_oh[i]  = 1'b1;
            pick_idx    = PTR_W'(i);
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/taus88_req_arbiter.sv
// Round-robin sharing of one Taus88 core among NUM_REQ requesters, with warm-up
// sequencing and seed loading. Optional grant statistics: TAUS88_ARB_STATS_EN.
module taus88_req_arbiter
   import taus88_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int WARMUP_N = DEFAULT_WARMUP_N
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [31:0]               rnd,
   input  logic                      seed_valid,
   input  logic [31:0]               seed,
   output logic                      seed_ready,
   input  logic [31:0]               core_rnd,
   input  logic                      core_ready,
   output logic                      core_adv,
   output logic                      core_re_seed,
   output logic [31:0]               core_seed,
   output logic [NUM_REQ*STAT_W-1:0] stat_cnt
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WCNT_W = (WARMUP_N > 0) ? $clog2(WARMUP_N + 1) : 1;

   arb_state_t          state;
   logic [WCNT_W-1:0]   wcnt;
   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    rr_next;
   logic [NUM_REQ-1:0]  pick_oh;
   logic [PTR_W-1:0]    pick_idx;
   logic                any_req;
   logic                pick;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req      (req),
      .rr_ptr   (rr_ptr),
      .pick_oh  (pick_oh),
      .pick_idx (pick_idx),
      .any_req  (any_req)
   );

   // A seed request always beats a pick, so the core is never advanced in an accept cycle.
   always_comb begin
      seed_ready   = (state == SERVE) && core_ready;
      pick         = seed_ready && !seed_valid && any_req;
      core_adv     = pick || ((state == WARMUP) && core_ready);
      core_re_seed = (state == RESEED) && core_ready;
      rr_next      = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RESET_WAIT;
         wcnt      <= '0;
         rr_ptr    <= '0;
         gnt       <= '0;
         rnd       <= '0;
         core_seed <= '0;
      end else begin
         gnt <= '0;
         if (!core_ready && (state != RESET_WAIT)) begin
            state <= RESET_WAIT;
         end else begin
            case (state)
               RESET_WAIT, RESEED: begin
                  if (core_ready) begin
                     if (WARMUP_N == 0) begin
                        state <= SERVE;
                     end else begin
                        state <= WARMUP;
                        wcnt  <= WCNT_W'(WARMUP_N);
                     end
                  end
               end
               WARMUP: begin
                  wcnt <= wcnt - WCNT_W'(1);
                  if (wcnt == WCNT_W'(1)) begin
                     state <= SERVE;
                  end
               end
               SERVE: begin
                  if (seed_valid) begin
                     core_seed <= seed;
                     state     <= RESEED;
                  end else if (any_req) begin
                     gnt    <= pick_oh;
                     rnd    <= core_rnd;
                     rr_ptr <= rr_next;
                  end
               end
               default: state <= RESET_WAIT;
            endcase
         end
      end
   end

`ifdef TAUS88_ARB_STATS_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      logic [STAT_W-1:0] cnt;

      // Saturating so a long-running requester never wraps back to a small count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (gnt[i] && (cnt != '1)) begin
            cnt <= cnt + STAT_W'(1);
         end
      end

      assign stat_cnt[i*STAT_W +: STAT_W] = cnt;
   end
`else
   assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_taus88_req_arbiter.sv
// Self-checking bench for taus88_req_arbiter: a behavioural Taus88 core drives the
// DUT while a spec-level scheduler model predicts every output each cycle.
module tb_taus88_req_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int WARMUP_N = 8;
   localparam logic [95:0] CORE_INIT = {32'h1F2E3D4C, 32'h5A6B7C8D, 32'h9E0F1A2B};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic        seed_valid;
   logic [31:0] seed;
   logic        core_ready;
   logic [3:0]  gnt;
   logic [31:0] rnd;
   logic        seed_ready;
   logic [31:0] core_rnd;
   logic        core_adv;
   logic        core_re_seed;
   logic [31:0] core_seed;
   logic [63:0] stat_cnt;

   logic [95:0] core_st = CORE_INIT;
   logic [95:0] gold    = CORE_INIT;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  last_gnt = 4'b0000;

   bit          m_ready_seen;
   int          m_warm_left;
   bit          m_reseed_pending;
   int          m_rr;
   logic [3:0]  e_gnt;
   logic [31:0] e_rnd;
   logic [31:0] e_seed;
   int          e_cnt [NUM_REQ];

   always #5 clk = ~clk;

   taus88_req_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .WARMUP_N (WARMUP_N)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .gnt          (gnt),
      .rnd          (rnd),
      .seed_valid   (seed_valid),
      .seed         (seed),
      .seed_ready   (seed_ready),
      .core_rnd     (core_rnd),
      .core_ready   (core_ready),
      .core_adv     (core_adv),
      .core_re_seed (core_re_seed),
      .core_seed    (core_seed),
      .stat_cnt     (stat_cnt)
   );

   function automatic logic [95:0] taus_next(input logic [95:0] st);
      logic [31:0] s1, s2, s3, b;
      s1 = st[95:64];
      s2 = st[63:32];
      s3 = st[31:0];
      b  = ((s1 << 13) ^ s1) >> 19;
      s1 = ((s1 & 32'hFFFFFFFE) << 12) ^ b;
      b  = ((s2 << 2) ^ s2) >> 25;
      s2 = ((s2 & 32'hFFFFFFF8) << 4) ^ b;
      b  = ((s3 << 3) ^ s3) >> 11;
      s3 = ((s3 & 32'hFFFFFFF0) << 17) ^ b;
      return {s1, s2, s3};
   endfunction

   function automatic logic [31:0] taus_word(input logic [95:0] st);
      return st[95:64] ^ st[63:32] ^ st[31:0];
   endfunction

   // Stand-in for the shared taus88_core: reseed loads S1 only, advance steps all three.
   always @(posedge clk) begin
      if (core_re_seed) begin
         core_st[95:64] <= core_seed;
      end else if (core_adv) begin
         core_st <= taus_next(core_st);
      end
   end

   assign core_rnd = taus_word(core_st);

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      m_ready_seen     = 1'b0;
      m_warm_left      = 0;
      m_reseed_pending = 1'b0;
      m_rr             = 0;
      e_gnt            = 4'b0000;
      e_rnd            = 32'h0;
      e_seed           = 32'h0;
      for (int i = 0; i < NUM_REQ; i++) e_cnt[i] = 0;
   endtask

   // What the scheduler must do this cycle given its phase and the live inputs.
   task automatic modelComb(output bit adv, output bit rs, output bit sr, output int pick);
      adv  = 1'b0;
      rs   = 1'b0;
      sr   = 1'b0;
      pick = -1;
      if (!rst_n || !core_ready || !m_ready_seen) return;
      if (m_reseed_pending) begin
         rs = 1'b1;
         return;
      end
      if (m_warm_left > 0) begin
         adv = 1'b1;
         return;
      end
      sr = 1'b1;
      if (seed_valid) return;
      for (int k = 0; k < NUM_REQ; k++) begin
         int j;
         j = (m_rr + k) % NUM_REQ;
         if (pick < 0 && ((req >> j) & 4'b0001) != 4'b0000) pick = j;
      end
      adv = (pick >= 0);
   endtask

   task automatic modelStep();
      bit adv, rs, sr;
      int pick;
      if (!rst_n) begin
         modelReset();
         return;
      end
      modelComb(adv, rs, sr, pick);
      for (int i = 0; i < NUM_REQ; i++) if (e_gnt[i]) e_cnt[i]++;
      e_gnt = 4'b0000;
      if (!core_ready) begin
         m_ready_seen     = 1'b0;
         m_warm_left      = 0;
         m_reseed_pending = 1'b0;
      end else if (!m_ready_seen) begin
         m_ready_seen = 1'b1;
         m_warm_left  = WARMUP_N;
      end else if (rs) begin
         gold[95:64]      = e_seed;
         m_reseed_pending = 1'b0;
         m_warm_left      = WARMUP_N;
      end else if (adv && pick < 0) begin
         gold = taus_next(gold);
         m_warm_left--;
      end else if (sr && seed_valid) begin
         e_seed           = seed;
         m_reseed_pending = 1'b1;
      end else if (pick >= 0) begin
         e_gnt = 4'(1 << pick);
         e_rnd = taus_word(gold);
         gold  = taus_next(gold);
         m_rr  = (pick + 1) % NUM_REQ;
      end
   endtask

   task automatic checkOutput();
      logic [63:0] es;
      es = '0;
`ifdef TAUS88_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++) es[i*16 +: 16] = (e_cnt[i] > 65535) ? 16'hFFFF : 16'(e_cnt[i]);
`endif
      check("gnt", gnt, e_gnt);
      check("rnd", rnd, e_rnd);
      check("core_seed", core_seed, e_seed);
      check("stat_cnt", stat_cnt, es);
      last_gnt = gnt;
   endtask

   task automatic checkComb();
      bit adv, rs, sr;
      int pick;
      modelComb(adv, rs, sr, pick);
      check("core_adv", core_adv, adv);
      check("core_re_seed", core_re_seed, rs);
      if (core_ready) check("seed_ready", seed_ready, sr);
   endtask

   task automatic checkResetLiterals(input string tag);
      check({tag, "_gnt"}, gnt, 0);
      check({tag, "_rnd"}, rnd, 0);
      check({tag, "_core_seed"}, core_seed, 0);
      check({tag, "_core_adv"}, core_adv, 0);
      check({tag, "_core_re_seed"}, core_re_seed, 0);
      check({tag, "_seed_ready"}, seed_ready, 0);
      check({tag, "_stat_cnt"}, stat_cnt, 0);
   endtask

   task automatic applyStimulus(input logic rn, input logic [3:0] r, input bit sv,
                                input logic [31:0] s, input bit cr);
      rst_n      = rn;
      req        = r;
      seed_valid = sv;
      seed       = s;
      core_ready = cr;
   endtask

   task automatic cycleA(input logic rn, input logic [3:0] r, input bit sv,
                         input logic [31:0] s, input bit cr);
      @(negedge clk);
      checkOutput();
      applyStimulus(rn, r, sv, s, cr);
      #1;
      checkComb();
   endtask

   task automatic cycleB();
      @(posedge clk);
      modelStep();
   endtask

   task automatic runCycle(input logic rn, input logic [3:0] r, input bit sv,
                           input logic [31:0] s, input bit cr);
      cycleA(rn, r, sv, s, cr);
      cycleB();
   endtask

   // Counts advance pulses before the first SERVE cycle, bounded so a stuck DUT still ends.
   task automatic warmCount(input string tag, input logic [3:0] r);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         cycleA(1'b1, r, 1'b0, 32'h0, 1'b1);
         done = seed_ready;
         if (core_adv && !seed_ready) n++;
         cycleB();
      end
      check({tag, "_reached_serve"}, done, 1);
      check({tag, "_adv_pulses"}, n, 8);
   endtask

   initial begin
      logic [3:0]  obs [6];
      logic [31:0] words [6];
      logic [3:0]  seq_all [5];
      logic [3:0]  seq_alt [4];
      logic [3:0]  pend;

      seq_all = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      seq_alt = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

      applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 1'b1);
      modelReset();
      #1;
      checkResetLiterals("por");
      runCycle(1'b0, 4'b0000, 1'b0, 32'h0, 1'b1);
      runCycle(1'b0, 4'b0000, 1'b0, 32'h0, 1'b1);

      $display("[TB] reset release warm-up");
      warmCount("por_warmup", 4'b0000);

      $display("[TB] all requesters held");
      for (int k = 0; k < 6; k++) begin
         runCycle(1'b1, (k < 5) ? 4'b1111 : 4'b0000, 1'b0, 32'h0, 1'b1);
         obs[k]   = last_gnt;
         words[k] = rnd;
      end
      for (int k = 0; k < 5; k++) check($sformatf("rr_all_%0d", k), obs[k+1], seq_all[k]);
      for (int k = 2; k < 6; k++) check($sformatf("rnd_no_repeat_%0d", k), words[k] != words[k-1], 1);

      $display("[TB] requesters 1 and 3 held");
      runCycle(1'b1, 4'b1000, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         runCycle(1'b1, (k < 4) ? 4'b1010 : 4'b0000, 1'b0, 32'h0, 1'b1);
         obs[k] = last_gnt;
      end
      for (int k = 0; k < 4; k++) check($sformatf("rr_alt_%0d", k), obs[k+1], seq_alt[k]);

      $display("[TB] seed load");
      runCycle(1'b1, 4'b0001, 1'b1, 32'h12345678, 1'b1);
      cycleA(1'b1, 4'b0001, 1'b0, 32'h0, 1'b1);
      check("seed_accept_no_gnt", gnt, 0);
      check("reseed_pulse", core_re_seed, 1);
      check("reseed_value", core_seed, 32'h12345678);
      cycleB();
      warmCount("seed_warmup", 4'b0001);
      for (int k = 0; k < 4; k++) runCycle(1'b1, 4'b0001, 1'b0, 32'h0, 1'b1);

      $display("[TB] reset during warm-up");
      runCycle(1'b0, 4'b0000, 1'b0, 32'h0, 1'b1);
      runCycle(1'b1, 4'b0000, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 5; k++) runCycle(1'b1, 4'b0000, 1'b0, 32'h0, 1'b1);
      cycleA(1'b1, 4'b0000, 1'b0, 32'h0, 1'b1);
      check("mid_warmup_adv", core_adv, 1);
      #2 rst_n = 1'b0;
      #1;
      checkResetLiterals("mid_warmup_rst");
      cycleB();
      runCycle(1'b0, 4'b0000, 1'b0, 32'h0, 1'b1);
      warmCount("rewarm", 4'b0000);

      $display("[TB] randomized traffic");
      pend = 4'b0000;
      for (int c = 0; c < 800; c++) begin
         pend = pend & ~last_gnt;
         if ($urandom_range(0, 2) == 0) pend = pend | 4'($urandom_range(0, 15));
         runCycle(1'b1, pend, $urandom_range(0, 29) == 0, $urandom, $urandom_range(0, 39) != 0);
      end

      $display("[TB] grant statistics");
      runCycle(1'b0, 4'b0000, 1'b0, 32'h0, 1'b1);
      runCycle(1'b0, 4'b0000, 1'b0, 32'h0, 1'b1);
      warmCount("stat_warmup", 4'b0000);
`ifdef TAUS88_ARB_STATS_EN
      for (int c = 0; c < 70000; c++) runCycle(1'b1, 4'b0001, 1'b0, 32'h0, 1'b1);
      runCycle(1'b1, 4'b0000, 1'b0, 32'h0, 1'b1);
      runCycle(1'b1, 4'b0000, 1'b0, 32'h0, 1'b1);
      check("stat_saturated", stat_cnt, 64'h0000_0000_0000_FFFF);
`else
      for (int c = 0; c < 20; c++) runCycle(1'b1, 4'b0001, 1'b0, 32'h0, 1'b1);
      runCycle(1'b1, 4'b0000, 1'b0, 32'h0, 1'b1);
      check("stat_tied_zero", stat_cnt, 0);
`endif
      runCycle(1'b1, 4'b0000, 1'b0, 32'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
